stream_packer: RTL and testbench

- Valid/ready width upsizer that sits directly downstream of the HandshakeReg slice.
- Collects N consecutive W-bit beats into one N*W-bit word and emits it with a per-lane keep mask and a packet-end flag.
- An input packet-end flag (inLast) flushes a partially filled word early, so packets never merge across a word.
- Feeds wide internal datapaths from narrow stream sources.

---
 rtl/stream_packer.sv | 114 +++++++++++
 tb/tb_stream_packer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_packer.sv
// stream_packer: packs N consecutive W-bit beats into one N*W-bit word with a lane keep mask; inLast flushes a partial word early.
// Latency: the word is valid on the cycle after its completing beat is accepted; full throughput with outReady held high.
// Backpressure: inReady = !outValid || outReady; a held word stalls input, a draining word lets a new beat in on the same edge.
module stream_packer #(
  parameter int W = 16,
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inValid,
  output logic             inReady,
  input  logic [W-1:0]     dIn,
  input  logic             inLast,
  output logic             outValid,
  input  logic             outReady,
  output logic [N*W-1:0]   dOut,
  output logic [N-1:0]     outKeep,
  output logic             outLast
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_LANE = CW'(N - 1);

  logic [CW-1:0]  cnt_q,  cnt_d;
  logic [N*W-1:0] acc_q,  acc_d;
  logic [N*W-1:0] dout_q, dout_d;
  logic [N-1:0]   keep_q, keep_d;
  logic           last_q, last_d;
  logic           vld_q,  vld_d;

  logic           in_rdy;
  logic           accept;
  logic           complete;
  logic [N*W-1:0] word;
  logic [N-1:0]   word_keep;

  // Handshake: input readiness depends only on the output register and downstream ready.
  always_comb begin
    in_rdy   = !vld_q || outReady;
    accept   = inValid && in_rdy;
    complete = accept && ((cnt_q == LAST_LANE) || inLast);
  end

  // Candidate word: lanes below cnt from the accumulator, lane cnt from the current beat, lanes above forced to zero.
  always_comb begin
    word      = '0;
    word_keep = '0;
    for (int k = 0; k < N; k++) begin
      if (k < int'(cnt_q)) begin
        word[k*W +: W] = acc_q[k*W +: W];
        word_keep[k]   = 1'b1;
      end else if (k == int'(cnt_q)) begin
        word[k*W +: W] = dIn;
        word_keep[k]   = 1'b1;
      end
    end
  end

  // Next state: accumulate non-completing beats, load the output register on a completing beat, drop valid on transfer.
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    dout_d = dout_q;
    keep_d = keep_q;
    last_d = last_q;
    vld_d  = vld_q;

    if (vld_q && outReady) begin
      vld_d = 1'b0;
    end

    if (complete) begin
      dout_d = word;
      keep_d = word_keep;
      last_d = inLast;
      vld_d  = 1'b1;
      acc_d  = '0;
      cnt_d  = '0;
    end else if (accept) begin
      for (int k = 0; k < N; k++) begin
        if (k == int'(cnt_q)) begin
          acc_d[k*W +: W] = dIn;
        end
      end
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; reset discards any partial word and clears the output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      dout_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      dout_q <= dout_d;
      keep_q <= keep_d;
      last_q <= last_d;
      vld_q  <= vld_d;
    end
  end

  assign inReady  = in_rdy;
  assign outValid = vld_q;
  assign dOut     = dout_q;
  assign outKeep  = keep_q;
  assign outLast  = last_q;

endmodule

// File: tb/tb_stream_packer.sv
// Bench for stream_packer (W=16, N=4): vector table, hand-written backpressure/reset sequences, randomized run vs. a packet model.
module tb_stream_packer;

  localparam int W = 16;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rstn;
  logic           inValid;
  logic           inReady;
  logic [W-1:0]   dIn;
  logic           inLast;
  logic           outValid;
  logic           outReady;
  logic [N*W-1:0] dOut;
  logic [N-1:0]   outKeep;
  logic           outLast;

  int checks   = 0;
  int failures = 0;

  stream_packer #(.W(W), .N(N)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .inValid  (inValid),
    .inReady  (inReady),
    .dIn      (dIn),
    .inLast   (inLast),
    .outValid (outValid),
    .outReady (outReady),
    .dOut     (dOut),
    .outKeep  (outKeep),
    .outLast  (outLast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] d;
    logic        last;
    logic        exp_vld;
    logic [63:0] exp_dout;
    logic [3:0]  exp_keep;
    logic        exp_last;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [15:0] d, input logic last, input logic vld,
                              input logic [63:0] dout, input logic [3:0] keep, input logic olast);
    vec_t v;
    v.d = d; v.last = last; v.exp_vld = vld;
    v.exp_dout = dout; v.exp_keep = keep; v.exp_last = olast;
    tbl.push_back(v);
  endfunction

  typedef struct {
    logic [63:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  word_t exp_q[$];

  // Send one beat at a negedge and advance to the next negedge (beat is taken on the edge between).
  task automatic send(input logic [15:0] d, input logic last);
    inValid = 1'b1; dIn = d; inLast = last;
    @(negedge clk);
  endtask

  initial begin
    word_t       w;
    logic [63:0] acc;
    int          lanes;
    int          beat;
    int          idle;
    int          cyc;

    rstn = 1'b0; inValid = 1'b0; dIn = '0; inLast = 1'b0; outReady = 1'b1;
    #1;
    chk("reset_out_valid", outValid, 0);
    chk("reset_dout", dOut, 0);
    chk("reset_keep", outKeep, 0);
    chk("reset_last", outLast, 0);
    chk("reset_in_ready", inReady, 1);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;

    // ---- table-driven vectors, continuous valid, outReady=1 ----
    for (int i = 0; i < 8; i++)
      add(16'(i), 1'b0, (i % 4) == 3,
          (i == 3) ? 64'h0003_0002_0001_0000 : 64'h0007_0006_0005_0004, 4'hF, 1'b0);
    add(16'hAAAA, 1'b0, 1'b0, 64'h0, 4'h0, 1'b0);
    add(16'hBBBB, 1'b1, 1'b1, 64'h0000_0000_BBBB_AAAA, 4'b0011, 1'b1);
    add(16'h1111, 1'b1, 1'b1, 64'h0000_0000_0000_1111, 4'b0001, 1'b1);
    add(16'h1234, 1'b1, 1'b1, 64'h0000_0000_0000_1234, 4'b0001, 1'b1);
    add(16'h0021, 1'b0, 1'b0, 64'h0, 4'h0, 1'b0);
    add(16'h0022, 1'b0, 1'b0, 64'h0, 4'h0, 1'b0);
    add(16'h0023, 1'b0, 1'b0, 64'h0, 4'h0, 1'b0);
    add(16'h0024, 1'b1, 1'b1, 64'h0024_0023_0022_0021, 4'hF, 1'b1);

    outReady = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      inValid = 1'b1; dIn = tbl[i].d; inLast = tbl[i].last;
      #1;
      chk($sformatf("vec%0d_in_ready", i), inReady, 1);
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), outValid, tbl[i].exp_vld);
      if (tbl[i].exp_vld) begin
        chk($sformatf("vec%0d_dout", i), dOut, tbl[i].exp_dout);
        chk($sformatf("vec%0d_keep", i), outKeep, tbl[i].exp_keep);
        chk($sformatf("vec%0d_last", i), outLast, tbl[i].exp_last);
      end
    end
    inValid = 1'b0; inLast = 1'b0;
    @(negedge clk);

    // ---- hold: word pending with outReady=0 for 10 cycles ----
    outReady = 1'b0;
    for (int i = 0; i < 4; i++) send(16'h0040 + 16'(i), 1'b0);
    inValid = 1'b1; dIn = 16'h0099; inLast = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("hold%0d_in_ready", i), inReady, 0);
      chk($sformatf("hold%0d_out_valid", i), outValid, 1);
      chk($sformatf("hold%0d_dout", i), dOut, 64'h0043_0042_0041_0040);
      chk($sformatf("hold%0d_keep", i), outKeep, 4'hF);
      chk($sformatf("hold%0d_last", i), outLast, 0);
      @(negedge clk);
    end
    outReady = 1'b1;
    #1;
    chk("hold_release_in_ready", inReady, 1);
    @(negedge clk);
    chk("hold_drained_out_valid", outValid, 0);
    send(16'h009A, 1'b1);
    chk("hold_next_out_valid", outValid, 1);
    chk("hold_next_dout", dOut, 64'h0000_0000_009A_0099);
    chk("hold_next_keep", outKeep, 4'b0011);
    chk("hold_next_last", outLast, 1);
    inValid = 1'b0; inLast = 1'b0;
    @(negedge clk);
    chk("hold_idle_out_valid", outValid, 0);

    // ---- reset while a word is held ----
    outReady = 1'b0;
    send(16'h0070, 1'b0);
    send(16'h0071, 1'b1);
    inValid = 1'b0; inLast = 1'b0;
    chk("rst1_pre_out_valid", outValid, 1);
    #2 rstn = 1'b0;
    #1;
    chk("rst1_out_valid", outValid, 0);
    chk("rst1_dout", dOut, 0);
    chk("rst1_keep", outKeep, 0);
    chk("rst1_last", outLast, 0);
    @(negedge clk);
    rstn = 1'b1;

    // ---- reset with a partial word in progress ----
    outReady = 1'b1;
    send(16'h0050, 1'b0);
    send(16'h0051, 1'b0);
    inValid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("rst2_out_valid", outValid, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) send(16'h0010 + 16'(i), 1'b0);
    inValid = 1'b0;
    chk("rst2_word_valid", outValid, 1);
    chk("rst2_dout", dOut, 64'h0013_0012_0011_0010);
    chk("rst2_keep", outKeep, 4'hF);
    chk("rst2_last", outLast, 0);
    @(negedge clk);

    // ---- randomized run: 4096 incrementing beats, inLast every 7th ----
    acc = '0; lanes = 0;
    for (int i = 0; i < 4096; i++) begin
      acc[lanes*16 +: 16] = 16'(i);
      lanes++;
      if (lanes == N || (i % 7) == 6) begin
        w.d = acc; w.k = 4'((1 << lanes) - 1); w.l = ((i % 7) == 6);
        exp_q.push_back(w);
        acc = '0; lanes = 0;
      end
    end

    beat = 0; idle = 0; cyc = 0;
    while (exp_q.size() > 0 && idle <= 1000 && cyc < 40000) begin
      cyc++;
      outReady = ($urandom % 3) != 0;
      if (beat < 4096) begin
        inValid = ($urandom % 3) != 0;
        dIn = 16'(beat);
        inLast = (beat % 7) == 6;
      end else begin
        inValid = 1'b0;
      end
      #1;
      chk("rnd_in_ready", inReady, !outValid || outReady);
      if (outValid && outReady) begin
        idle = 0;
        w = exp_q.pop_front();
        chk("rnd_dout", dOut, w.d);
        chk("rnd_keep", outKeep, w.k);
        chk("rnd_last", outLast, w.l);
      end else begin
        idle++;
      end
      if (inValid && inReady) beat++;
      @(negedge clk);
    end
    chk("rnd_words_left", exp_q.size(), 0);
    chk("rnd_beats_taken", beat, 4096);

    // The trailing beat has no inLast and must stay in the accumulator.
    inValid = 1'b0; inLast = 1'b0; outReady = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("rnd_no_extra_word", outValid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
